// File: rtl/ofs_pkg.sv
// Shared types and widths for the operand fetch sequencer.
// The optional write-back bypass is enabled by defining OFS_BYPASS_EN.
package ofs_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WIN_W  = 2;
    localparam int unsigned DATA_W = 32;

    localparam logic RF_READ  = 1'b0;
    localparam logic RF_WRITE = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        RD_A,
        RD_B,
        DONE
    } ofs_state_e;

endpackage

// File: rtl/ofs_operand_latch.sv
// Load-enabled operand register with asynchronous active-low clear.
module ofs_operand_latch
    import ofs_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              load_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);

    logic [DATA_W-1:0] data_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q <= '0;
        end else if (load_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/operand_fetch_sequencer.sv
// Fetches one or two operands from a windowed register file, giving write-backs priority.
// Define OFS_BYPASS_EN to forward a colliding write-back straight into the operand.
module operand_fetch_sequencer
    import ofs_pkg::*;
(
    input  logic              Clk,
    input  logic              Clr,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [REG_W-1:0]  req_rs1,
    input  logic [REG_W-1:0]  req_rs2,
    input  logic              req_use_rs2,
    input  logic [WIN_W-1:0]  req_window,
    output logic              op_valid,
    input  logic              op_ready,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              wb_valid,
    output logic              wb_ready,
    input  logic [REG_W-1:0]  wb_rd,
    input  logic [WIN_W-1:0]  wb_window,
    input  logic [DATA_W-1:0] wb_data,
    output logic              rf_enable,
    output logic              rf_rw,
    output logic [REG_W-1:0]  rf_r_num,
    output logic [WIN_W-1:0]  rf_window,
    output logic [DATA_W-1:0] rf_in,
    input  logic [DATA_W-1:0] rf_out
);

    ofs_state_e        state_q;
    logic [REG_W-1:0]  rs1_q;
    logic [REG_W-1:0]  rs2_q;
    logic              use_rs2_q;
    logic [WIN_W-1:0]  window_q;
    logic              op_valid_q;

    logic              wb_go;
    logic              rd_state;
    logic              read_go;
    logic              bypass;
    logic              step;
    logic [REG_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              load_a;
    logic              load_b;
    logic [DATA_W-1:0] d_b;

    // Gating with Clr keeps the RF port silent while reset is held.
    assign wb_go    = Clr & wb_valid;
    assign rd_state = (state_q == RD_A) || (state_q == RD_B);
    assign rd_addr  = (state_q == RD_B) ? rs2_q : rs1_q;
    assign read_go  = Clr & rd_state & ~wb_valid;

`ifdef OFS_BYPASS_EN
    assign bypass = wb_go && rd_state && (rd_addr != '0) &&
                    (wb_rd == rd_addr) && (wb_window == window_q);
`else
    assign bypass = 1'b0;
`endif

    assign step    = read_go | bypass;
    assign rd_data = bypass ? wb_data : ((rd_addr == '0) ? '0 : rf_out);

    assign load_a = step && (state_q == RD_A);
    assign load_b = step && ((state_q == RD_B) || !use_rs2_q);
    assign d_b    = (state_q == RD_B) ? rd_data : '0;

    assign req_ready = Clr && (state_q == IDLE) && !wb_valid;
    assign wb_ready  = wb_go;
    assign op_valid  = op_valid_q;

    always_comb begin
        rf_enable = 1'b0;
        rf_rw     = RF_READ;
        rf_r_num  = '0;
        rf_window = '0;
        rf_in     = '0;
        if (wb_go) begin
            rf_enable = 1'b1;
            rf_rw     = RF_WRITE;
            rf_r_num  = wb_rd;
            rf_window = wb_window;
            rf_in     = wb_data;
        end else if (read_go) begin
            rf_enable = 1'b1;
            rf_rw     = RF_READ;
            rf_r_num  = rd_addr;
            rf_window = window_q;
        end
    end

    always_ff @(posedge Clk or negedge Clr) begin
        if (!Clr) begin
            state_q    <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            use_rs2_q  <= 1'b0;
            window_q   <= '0;
            op_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        rs1_q     <= req_rs1;
                        rs2_q     <= req_rs2;
                        use_rs2_q <= req_use_rs2;
                        window_q  <= req_window;
                        state_q   <= RD_A;
                    end
                end
                RD_A: begin
                    if (step) begin
                        if (use_rs2_q) begin
                            state_q <= RD_B;
                        end else begin
                            state_q    <= DONE;
                            op_valid_q <= 1'b1;
                        end
                    end
                end
                RD_B: begin
                    if (step) begin
                        state_q    <= DONE;
                        op_valid_q <= 1'b1;
                    end
                end
                DONE: begin
                    if (op_ready) begin
                        state_q    <= IDLE;
                        op_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    ofs_operand_latch u_op_a (
        .clk_i  (Clk),
        .rst_ni (Clr),
        .load_i (load_a),
        .d_i    (rd_data),
        .q_o    (op_a)
    );

    ofs_operand_latch u_op_b (
        .clk_i  (Clk),
        .rst_ni (Clr),
        .load_i (load_b),
        .d_i    (d_b),
        .q_o    (op_b)
    );

endmodule
